sdram_bank_rcd_timer: RTL
=========================

// Module: sdram_bank_rcd_timer
// PURPOSE
//  Multi-bank RAS-to-CAS (tRCD) delay tracker for the SDRAM controller.
//  Holds one down-counter and one state machine per bank. Each counter is loaded
//  on ACTIVATE from the ras_cas config field. The block pulses do_rw per bank when
//  tRCD has elapsed, and grants queued READA/WRITEA requests only to open, timed-out banks.
//  Sits between the command sequencer and the command encoder.
// PARAMETERS
//  NUM_BANKS  4  number of independently tracked SDRAM banks
//  BA_W       2  bank-address width; NUM_BANKS <= 2**BA_W
//  RC_W       4  ras_cas config width; supports tRCD values 1..2**RC_W-1
// PORTS
//  clk0      in   1          system clock, rising edge
//  reset     in   1          synchronous, active-high reset
//  act       in   1          ACTIVATE issued this cycle to bank act_ba
//  act_ba    in   BA_W       bank of ACTIVATE
//  ras_cas   in   RC_W       tRCD in clk0 cycles, sampled only when act=1
//  pre       in   1          PRECHARGE issued this cycle to bank pre_ba
//  pre_ba    in   BA_W       bank of PRECHARGE
//  pre_all   in   1          PRECHARGE-ALL: closes every bank
//  rw_req    in   1          READA/WRITEA request pending for bank rw_ba
//  rw_ba     in   BA_W       bank of request
//  do_rw     out  NUM_BANKS  one-cycle pulse per bank when its tRCD expires
//  bank_open out  NUM_BANKS  bank is OPEN; column commands are legal
//  rw_gnt    out  1          one-cycle grant for rw_req
//  rcd_err   out  1          protocol-error pulse (RCD_CHECK_EN only)
// BEHAVIOUR
//  - Reset is synchronous. All banks go to IDLE with cnt=0. do_rw, bank_open,
//    rw_gnt and rcd_err all reset to 0. Reset mid-countdown aborts without a pulse.
//  - Per-bank FSM states: IDLE, WAIT, OPEN.
//    IDLE/WAIT/OPEN with act to this bank: cnt <= eff-1, next state WAIT.
//    eff = (ras_cas==0) ? 1 : ras_cas. A re-activate restarts the count.
//    WAIT: if cnt==0, go to OPEN and do_rw[b] <= 1 for one cycle; else cnt <= cnt-1.
//    WAIT/OPEN with pre to this bank, or with pre_all: go to IDLE with no do_rw pulse.
//  - Latency: with act sampled at edge t and eff=N, do_rw[b] is high during the
//    cycle after edge t+N. bank_open[b] rises on the same edge and stays high.
//  - act and pre to the same bank in one cycle: act wins.
//    act and pre_all in one cycle: the act bank enters WAIT; all others go IDLE.
//  - act, pre and rw_req may target different banks in one cycle; they are
//    processed independently.
//  - Grant handshake: rw_gnt <= rw_req & bank_open[rw_ba] & ~rw_gnt (registered).
//    The requester holds rw_req and rw_ba stable until rw_gnt, then drops or
//    changes them. Because of the ~rw_gnt term, back-to-back grants are never
//    issued, which gives at least one idle cycle between column commands.
//  - A request to a bank being precharged in the same cycle is not granted
//    (the grant uses the current bank_open).
//  - Counters saturate at 0 and never wrap. ras_cas values above 2**RC_W-1 cannot occur.
// CONFIGURATION
//  - Macro RCD_CHECK_EN defined: rcd_err <= 1 for one cycle when any of these holds:
//    (a) act targets a bank in WAIT or OPEN;
//    (b) rw_req is high while its bank is IDLE;
//    (c) act_ba, pre_ba or rw_ba >= NUM_BANKS while the qualifying strobe is high.
//    Any command to an out-of-range bank is otherwise ignored.
//  - Macro RCD_CHECK_EN undefined: rcd_err is tied to 0 and the check logic is absent.
//    Case (a) still restarts the count.
// TESTING
//  1. Reset, then act ba=2 with ras_cas=3 at edge 0 -> do_rw=4'b0100 only in the
//     cycle after edge 3; bank_open[2]=1 from edge 3.
//  2. act ba=0 with ras_cas=0 -> behaves as 1: do_rw[0] pulses the cycle after the next edge.
//  3. act ba=1 with ras_cas=5, then pre ba=1 at edge 2 -> no do_rw[1]; bank_open[1] stays 0.
//  4. Hold rw_req with rw_ba=3 from edge 0; act ba=3 with ras_cas=2 at edge 0 ->
//     rw_gnt=1 exactly one cycle after bank_open[3] rises, then 0 while rw_req is still held.
//  5. Banks 0 and 1 in WAIT; pre_all and act ba=1 with ras_cas=2 in the same cycle ->
//     bank 0 IDLE with no pulse; bank 1 pulses 2 cycles later.
//  6. RCD_CHECK_EN: act to an OPEN bank -> rcd_err one-cycle pulse and the count
//     restarts; the same stimulus without the macro -> rcd_err stays 0.

Source files
------------

// File: rtl/sdram_bank_rcd_timer.sv
// rtl/sdram_bank_rcd_timer.sv - per-bank tRCD timer with column-command grant
// Optional protocol checking enabled by defining RCD_CHECK_EN.
module sdram_bank_rcd_timer #(
    parameter int NUM_BANKS = 4,
    parameter int BA_W      = 2,
    parameter int RC_W      = 4
) (
    input  logic                 clk0,
    input  logic                 reset,
    input  logic                 act,
    input  logic [BA_W-1:0]      act_ba,
    input  logic [RC_W-1:0]      ras_cas,
    input  logic                 pre,
    input  logic [BA_W-1:0]      pre_ba,
    input  logic                 pre_all,
    input  logic                 rw_req,
    input  logic [BA_W-1:0]      rw_ba,
    output logic [NUM_BANKS-1:0] do_rw,
    output logic [NUM_BANKS-1:0] bank_open,
    output logic                 rw_gnt,
    output logic                 rcd_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_OPEN} state_t;

    state_t                 state_q [NUM_BANKS];
    state_t                 state_d [NUM_BANKS];
    logic [RC_W-1:0]        cnt_q   [NUM_BANKS];
    logic [RC_W-1:0]        cnt_d   [NUM_BANKS];
    logic [NUM_BANKS-1:0]   do_rw_q, do_rw_d;
    logic                   rw_gnt_q, rw_gnt_d;
    logic [NUM_BANKS-1:0]   act_hit, pre_hit, rw_hit;
    logic [RC_W-1:0]        eff;
    logic                   rw_open;
    logic                   rw_closing;

    // A tRCD of zero is treated as one cycle so the bank always passes through WAIT.
    assign eff = (ras_cas == '0) ? RC_W'(1) : ras_cas;

    always_comb begin
        act_hit    = '0;
        pre_hit    = '0;
        rw_hit     = '0;
        bank_open  = '0;
        rw_open    = 1'b0;
        rw_closing = 1'b0;
        do_rw_d    = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            act_hit[b]   = act    && (int'(act_ba) == b);
            pre_hit[b]   = pre    && (int'(pre_ba) == b);
            rw_hit[b]    = rw_req && (int'(rw_ba)  == b);
            bank_open[b] = (state_q[b] == ST_OPEN);
            if (rw_hit[b] && bank_open[b])
                rw_open = 1'b1;
            if (rw_hit[b] && (pre_hit[b] || pre_all))
                rw_closing = 1'b1;
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            cnt_d[b]   = cnt_q[b];
            if (act_hit[b]) begin
                state_d[b] = ST_WAIT;
                cnt_d[b]   = eff - RC_W'(1);
            end else if ((pre_hit[b] || pre_all) && state_q[b] != ST_IDLE) begin
                state_d[b] = ST_IDLE;
                cnt_d[b]   = '0;
            end else if (state_q[b] == ST_WAIT) begin
                if (cnt_q[b] == '0) begin
                    state_d[b] = ST_OPEN;
                    do_rw_d[b] = 1'b1;
                end else begin
                    cnt_d[b] = cnt_q[b] - RC_W'(1);
                end
            end
        end

        // A bank closing on this edge cannot accept the column command.
        rw_gnt_d = rw_req && rw_open && !rw_closing && !rw_gnt_q;
    end

    always_ff @(posedge clk0) begin
        if (reset) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= ST_IDLE;
                cnt_q[b]   <= '0;
            end
            do_rw_q  <= '0;
            rw_gnt_q <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= state_d[b];
                cnt_q[b]   <= cnt_d[b];
            end
            do_rw_q  <= do_rw_d;
            rw_gnt_q <= rw_gnt_d;
        end
    end

    assign do_rw  = do_rw_q;
    assign rw_gnt = rw_gnt_q;

`ifdef RCD_CHECK_EN
    logic rcd_err_q, rcd_err_d;

    always_comb begin
        rcd_err_d = 1'b0;
        if (act    && int'(act_ba) >= NUM_BANKS) rcd_err_d = 1'b1;
        if (pre    && int'(pre_ba) >= NUM_BANKS) rcd_err_d = 1'b1;
        if (rw_req && int'(rw_ba)  >= NUM_BANKS) rcd_err_d = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (act_hit[b] && state_q[b] != ST_IDLE) rcd_err_d = 1'b1;
            if (rw_hit[b]  && state_q[b] == ST_IDLE) rcd_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk0) begin
        if (reset) rcd_err_q <= 1'b0;
        else       rcd_err_q <= rcd_err_d;
    end

    assign rcd_err = rcd_err_q;
`else
    assign rcd_err = 1'b0;
`endif

endmodule
